// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control, serial/parallel inputs and
// the registered word, serial taps, bit counter and word-complete pulse.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
);
    logic             en;
    logic [1:0]       mode;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic [CW-1:0]    count;
    logic             word_valid;

    modport master (
        output en, mode, sin_lsb, sin_msb, pin,
        input  q, sout_msb, sout_lsb, count, word_valid
    );

    modport slave (
        input  en, mode, sin_lsb, sin_msb, pin,
        output q, sout_msb, sout_lsb, count, word_valid
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal WIDTH-bit shift register / deserialiser: hold, shift left/right,
// parallel load, serial taps at both ends and a word-boundary pulse.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input logic                 clk,
    input logic                 rst,
    universal_shift_reg_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHL   = 2'b01,
        MODE_SHR   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mode_t            mode;
    logic [WIDTH-1:0] q_r,   q_nxt;
    logic [CW-1:0]    cnt_r, cnt_nxt;
    logic             wv_r,  wv_nxt;
    logic             at_last;

    assign mode    = mode_t'(bus.mode);
    assign at_last = (cnt_r == LAST);

    always_comb begin
        q_nxt   = q_r;
        cnt_nxt = cnt_r;
        wv_nxt  = 1'b0;
        if (bus.en) begin
            unique case (mode)
                MODE_HOLD: ;
                MODE_SHL: q_nxt = {q_r[WIDTH-2:0], bus.sin_lsb};
                MODE_SHR: q_nxt = {bus.sin_msb, q_r[WIDTH-1:1]};
                MODE_LOAD: begin
                    q_nxt   = bus.pin;
                    cnt_nxt = '0;
                end
                default: ;
            endcase
            // Both shift directions share one counter; the wrap edge is the pulse edge.
            if (mode == MODE_SHL || mode == MODE_SHR) begin
                cnt_nxt = at_last ? '0 : cnt_r + CW'(1);
                wv_nxt  = at_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r   <= '0;
            cnt_r <= '0;
            wv_r  <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            cnt_r <= cnt_nxt;
            wv_r  <= wv_nxt;
        end
    end

    assign bus.q          = q_r;
    assign bus.count      = cnt_r;
    assign bus.word_valid = wv_r;
    // Unregistered taps so the first bit of a loaded word is visible right after the load.
    assign bus.sout_msb   = q_r[WIDTH-1];
    assign bus.sout_lsb   = q_r[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench: WIDTH=8, 2 and 32 instances driven in lockstep and
// compared every cycle against an arithmetic reference model.
module tb_universal_shift_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, sl, sm;
    logic [1:0]  mode;
    logic [63:0] pin;

    int checks = 0;
    int passed = 0;

    int          widths [3] = '{8, 2, 32};
    logic [63:0] mq     [3];
    int          mcnt   [3];
    logic        mwv    [3];

    always #5 clk = ~clk;

    universal_shift_reg_if #(.WIDTH(8))  i8  ();
    universal_shift_reg_if #(.WIDTH(2))  i2  ();
    universal_shift_reg_if #(.WIDTH(32)) i32 ();

    assign i8.en  = en;  assign i8.mode  = mode; assign i8.sin_lsb  = sl; assign i8.sin_msb  = sm;
    assign i2.en  = en;  assign i2.mode  = mode; assign i2.sin_lsb  = sl; assign i2.sin_msb  = sm;
    assign i32.en = en;  assign i32.mode = mode; assign i32.sin_lsb = sl; assign i32.sin_msb = sm;
    assign i8.pin  = pin[7:0];
    assign i2.pin  = pin[1:0];
    assign i32.pin = pin[31:0];

    universal_shift_reg #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8.slave));
    universal_shift_reg #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(i2.slave));
    universal_shift_reg #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(i32.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k] = '0; mcnt[k] = 0; mwv[k] = 1'b0;
        end
    endtask

    // Reference: q as a W-bit number, count as shifts modulo W.
    task automatic model_clk();
        for (int k = 0; k < 3; k++) begin
            int          w;
            logic [63:0] mask;
            w = widths[k];
            mask = {64{1'b1}} >> (64 - w);
            mwv[k] = 1'b0;
            if (en) begin
                if (mode == 2'b01 || mode == 2'b10) begin
                    if (mode == 2'b01) mq[k] = ((mq[k] * 2) + 64'(sl)) & mask;
                    else               mq[k] = (mq[k] / 2) + (64'(sm) << (w - 1));
                    mcnt[k] = mcnt[k] + 1;
                    if (mcnt[k] == w) begin
                        mcnt[k] = 0;
                        mwv[k]  = 1'b1;
                    end
                end else if (mode == 2'b11) begin
                    mq[k]   = pin & mask;
                    mcnt[k] = 0;
                end
            end
        end
    endtask

    task automatic chk_dut(input int k, input logic [63:0] q, input logic [63:0] cnt,
                           input logic wv, input logic som, input logic sol);
        string p;
        p = $sformatf("w%0d", widths[k]);
        chk({p, "_q"},          q,   mq[k]);
        chk({p, "_count"},      cnt, 64'(mcnt[k]));
        chk({p, "_word_valid"}, 64'(wv),  64'(mwv[k]));
        chk({p, "_sout_msb"},   64'(som), (mq[k] >> (widths[k] - 1)) & 64'd1);
        chk({p, "_sout_lsb"},   64'(sol), mq[k] & 64'd1);
    endtask

    task automatic check_all();
        chk_dut(0, 64'(i8.q),  64'(i8.count),  i8.word_valid,  i8.sout_msb,  i8.sout_lsb);
        chk_dut(1, 64'(i2.q),  64'(i2.count),  i2.word_valid,  i2.sout_msb,  i2.sout_lsb);
        chk_dut(2, 64'(i32.q), 64'(i32.count), i32.word_valid, i32.sout_msb, i32.sout_lsb);
    endtask

    // Called at posedge+1; drives inputs, then samples 1 time unit after the next edge.
    task automatic step(input logic e, input logic [1:0] m, input logic a, input logic b,
                        input logic [63:0] p);
        en = e; mode = m; sl = a; sm = b; pin = p;
        @(posedge clk); #1;
        model_clk();
        check_all();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;
    endtask

    logic [7:0] bits_b2 = 8'hB2;
    logic [7:0] stream [2] = '{8'hA5, 8'h3C};

    initial begin
        en = 1'b0; mode = 2'b00; sl = 1'b0; sm = 1'b0; pin = '0;
        rst = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset asserted between edges on a preloaded register
        step(1'b1, 2'b11, 1'b0, 1'b0, {64{1'b1}});
        chk("t1_preload", 64'(i8.q), 64'hFF);
        en = 1'b1; mode = 2'b01; sl = 1'b1;
        async_reset();

        // Deserialise 1,0,1,1,0,0,1,0 MSB first
        step(1'b1, 2'b11, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b01, bits_b2[7-i], 1'b0, 64'd0);
        chk("t2_q", 64'(i8.q), 64'hB2);
        chk("t2_wv", 64'(i8.word_valid), 64'd1);

        // Continuous 16-bit stream, pulses only at shifts 8 and 16
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                logic [7:0] cur;
                cur = stream[w];
                step(1'b1, 2'b01, cur[7-i], 1'b0, 64'd0);
            end
            chk($sformatf("t3_q%0d", w), 64'(i8.q), 64'(stream[w]));
            chk($sformatf("t3_wv%0d", w), 64'(i8.word_valid), 64'd1);
        end

        // Load then shift right as a PISO
        step(1'b1, 2'b11, 1'b0, 1'b0, 64'h81);
        chk("t4_first_bit", 64'(i8.sout_lsb), 64'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 1'b0, 1'b0, 64'd0);
        chk("t4_q", 64'(i8.q), 64'd0);
        chk("t4_wv", 64'(i8.word_valid), 64'd1);

        // Enable and hold gaps inside a word
        step(1'b1, 2'b11, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, bits_b2[7-i], 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 1'b1, 1'b1, 64'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 2'b00, 1'b1, 1'b1, 64'd0);
        for (int i = 4; i < 8; i++) step(1'b1, 2'b01, bits_b2[7-i], 1'b0, 64'd0);
        chk("t5_q", 64'(i8.q), 64'hB2);
        chk("t5_wv", 64'(i8.word_valid), 64'd1);

        // Mid-word load and mid-word reset both restart the word
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b1, 1'b0, 64'd0);
        step(1'b1, 2'b11, 1'b0, 1'b0, 64'd0);
        chk("t6_load_cnt", 64'(i8.count), 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b01, 1'b1, 1'b0, 64'd0);
        chk("t6_load_wv", 64'(i8.word_valid), 64'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 2'b10, 1'b1, 1'b1, 64'd0);
        async_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 1'b1, 1'b1, 64'd0);
        chk("t6_rst_wv", 64'(i8.word_valid), 64'd1);

        // Randomised traffic with occasional asynchronous resets
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [1:0] m;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                async_reset();
            end else begin
                if (r < 8)       m = 2'b11;
                else if (r < 14) m = 2'b00;
                else if (r < 57) m = 2'b01;
                else             m = 2'b10;
                step($urandom_range(0, 9) != 0, m, 1'($urandom), 1'($urandom),
                     {$urandom, $urandom});
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
